apb_slv_mem: RTL and testbench

APB_SLV_MEM -- requirements
Module: apb_slv_mem

---
 rtl/apb_slv_pkg.sv | 18 +
 rtl/apb_slv_ram.sv | 34 +++
 rtl/apb_slv_mem.sv | 121 ++++++++++++
 tb/tb_apb_slv_mem.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB slave memory: FSM states, pprot bit
// positions and the strobe-width helper.
package apb_slv_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_SECURE_BIT = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_slv_ram.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and asynchronous read.
module apb_slv_ram
    import apb_slv_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int STRB_W     = strb_width(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_W-1:0]     i_strb,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset branch on purpose; resetting storage would
    // cost a clear path per bit and contents must survive presetn anyway.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_strb[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/apb_slv_mem.sv
// APB slave with a byte-strobed word memory and programmable wait states.
// Optional privileged-region check enabled by defining APB_SLV_PROT_CHK_EN.
module apb_slv_mem
    import apb_slv_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] PROT_BASE   = '0
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic                             psel,
    input  logic                             penable,
    input  logic                             pwrite,
    input  logic [ADDR_WIDTH-1:0]            paddr,
    input  logic [DATA_WIDTH-1:0]            pwdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] pstrb,
    input  logic [2:0]                       pprot,
    output logic [DATA_WIDTH-1:0]            prdata,
    output logic                             pready,
    output logic                             pslverr
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * STRB_W);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_strb;
    logic                  r_priv;
    logic [WCNT_W-1:0]     r_wcnt;

    logic                  w_setup;
    logic                  w_done;
    logic                  w_oor;
    logic                  w_prot_err;
    logic                  w_err;
    logic                  w_we;
    logic                  w_unused;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_setup = (r_state == ST_IDLE) && psel && !penable;
    // pready is gated by psel so an abandoned access never signals completion.
    assign pready  = (r_state == ST_ACCESS) && psel && (r_wcnt == '0);
    assign w_done  = pready && penable;
    assign w_oor   = {1'b0, r_addr} >= MEM_BYTES;

`ifdef APB_SLV_PROT_CHK_EN
    assign w_prot_err = (r_addr >= PROT_BASE) && !r_priv;
    assign w_unused   = ^pprot[2:1];
`else
    assign w_prot_err = 1'b0;
    assign w_unused   = ^{pprot[2:1], r_priv, PROT_BASE};
`endif

    assign w_err   = w_oor || w_prot_err;
    assign w_we    = w_done && r_write && !w_err;
    assign pslverr = pready && w_err;
    assign prdata  = (pready && !r_write && !w_err) ? w_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_setup)           w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (!psel || w_done)   w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_priv  <= 1'b0;
            r_wcnt  <= '0;
        end else if (w_setup) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
            r_priv  <= pprot[PPROT_PRIV_BIT];
            r_wcnt  <= WCNT_W'(WAIT_STATES);
        end else if ((r_state == ST_ACCESS) && (r_wcnt != '0)) begin
            r_wcnt  <= r_wcnt - WCNT_W'(1);
        end
    end

    apb_slv_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk   (pclk),
        .i_we    (w_we),
        .i_idx   (r_addr[OFF_W +: IDX_W]),
        .i_wdata (r_wdata),
        .i_strb  (r_strb),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_apb_slv_mem.sv
// Randomized bench for apb_slv_mem: two instances (2 and 0 wait states)
// checked every cycle against a byte-array memory model.
module tb_apb_slv_mem;

    localparam logic [31:0] PROT_BASE_TB = 32'h20;
    localparam int          MEM_BYTES    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             presetn;
    logic [1:0]       psel_v, penable_v, pwrite_v;
    logic [1:0][31:0] paddr_v, pwdata_v;
    logic [1:0][3:0]  pstrb_v;
    logic [1:0][2:0]  pprot_v;
    logic [1:0][31:0] prdata_v;
    logic [1:0]       pready_v, pslverr_v;

    logic [1:0][31:0] exp_prdata;
    logic [1:0]       exp_pready, exp_pslverr;
    logic [7:0]       mem_m [2][MEM_BYTES];
    int               n_tests = 0;
    int               n_fail  = 0;
    bit               cmp_en  = 1'b0;

    apb_slv_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(2), .PROT_BASE(PROT_BASE_TB)
    ) u_dut_ws2 (
        .pclk(clk), .presetn(presetn), .psel(psel_v[0]), .penable(penable_v[0]),
        .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]), .pstrb(pstrb_v[0]),
        .pprot(pprot_v[0]), .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0])
    );

    apb_slv_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0), .PROT_BASE(PROT_BASE_TB)
    ) u_dut_ws0 (
        .pclk(clk), .presetn(presetn), .psel(psel_v[1]), .penable(penable_v[1]),
        .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]), .pstrb(pstrb_v[1]),
        .pprot(pprot_v[1]), .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit model_err(input logic [31:0] addr, input logic [2:0] prot);
        bit e;
        e = (addr >= 32'd64);
`ifdef APB_SLV_PROT_CHK_EN
        e = e || ((addr >= PROT_BASE_TB) && !prot[0]);
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] addr);
        int base;
        base = int'(addr[5:2]) * 4;
        return {mem_m[d][base+3], mem_m[d][base+2], mem_m[d][base+1], mem_m[d][base]};
    endfunction

    task automatic model_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        int base;
        base = int'(addr[5:2]) * 4;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem_m[d][base+b] = data[b*8 +: 8];
        end
    endtask

    task automatic bus_idle(input int d);
        psel_v[d]      = 1'b0;
        penable_v[d]   = 1'b0;
        exp_pready[d]  = 1'b0;
        exp_pslverr[d] = 1'b0;
        exp_prdata[d]  = '0;
    endtask

    // Called just after a rising edge; returns just after the completion edge
    // with the bus idle, so consecutive calls run back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [2:0] prot, input int abort_at,
                        output logic [31:0] rd, output logic err);
        bit e;
        int ws;
        e  = model_err(addr, prot);
        ws = ws_of(d);
        rd = '0;
        err = 1'b0;
        bus_idle(d);
        psel_v[d]   = 1'b1;
        pwrite_v[d] = wr;
        paddr_v[d]  = addr;
        pwdata_v[d] = data;
        pstrb_v[d]  = strb;
        pprot_v[d]  = prot;
        @(posedge clk); #1;
        penable_v[d] = 1'b1;
        for (int k = 0; k <= ws; k++) begin
            if (k == abort_at) begin
                bus_idle(d);
                @(posedge clk); #1;
                return;
            end
            exp_pready[d]  = (k == ws);
            exp_pslverr[d] = (k == ws) && e;
            exp_prdata[d]  = ((k == ws) && !wr && !e) ? model_read(d, addr) : 32'h0;
            @(negedge clk);
            if (k == ws) begin
                rd  = prdata_v[d];
                err = pslverr_v[d];
            end
            @(posedge clk); #1;
        end
        if (wr && !e) model_write(d, addr, data, strb);
        bus_idle(d);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("pready[%0d]", d),  pready_v[d],  exp_pready[d]);
                check($sformatf("pslverr[%0d]", d), pslverr_v[d], exp_pslverr[d]);
                check($sformatf("prdata[%0d]", d),  prdata_v[d],  exp_prdata[d]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, old;
        logic        er;
        int          d, abort_at;

        presetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_idle(i);
            pwrite_v[i] = 1'b0;
            paddr_v[i]  = '0;
            pwdata_v[i] = '0;
            pstrb_v[i]  = '0;
            pprot_v[i]  = '0;
        end
        @(posedge clk); #1;
        cmp_en = 1'b1;
        check("reset_pready", pready_v[0], 1'b0);
        check("reset_prdata", prdata_v[0], 32'h0);
        @(posedge clk); #1;
        presetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++)
                xfer(i, 1'b1, 32'(w*4), $urandom, 4'hF, 3'b001, -1, rd, er);

        // penable without a setup phase must be ignored
        psel_v[0] = 1'b1; penable_v[0] = 1'b1; pwrite_v[0] = 1'b0; paddr_v[0] = 32'h8;
        repeat (2) @(posedge clk);
        #1;
        check("no_setup_pready", pready_v[0], 1'b0);
        bus_idle(0);
        @(posedge clk); #1;

        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b001, -1, rd, er);
        check("wr08_err", er, 1'b0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("rd08_data", rd, 32'hDEADBEEF);
        check("rd08_err", er, 1'b0);

        xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 3'b001, -1, rd, er);
        xfer(0, 1'b1, 32'h04, 32'h11223344, 4'b0101, 3'b001, -1, rd, er);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("strb_merge", rd, 32'hFF22FF44);

        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("oor_err", er, 1'b1);
        check("oor_data", rd, 32'h0);

        xfer(0, 1'b1, 32'h14, 32'h0BADF00D, 4'h0, 3'b001, -1, rd, er);
        check("strb0_err", er, 1'b0);

        xfer(1, 1'b1, 32'h10, 32'hA5A51234, 4'hF, 3'b001, -1, rd, er);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("ws0_b2b_data", rd, 32'hA5A51234);

        old = model_read(0, 32'h18);
        xfer(0, 1'b1, 32'h18, ~old, 4'hF, 3'b001, 1, rd, er);
        xfer(0, 1'b0, 32'h18, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("abort_nowrite", rd, old);

        // reset in the middle of a write access phase
        xfer(0, 1'b1, 32'h0C, 32'h5A5A0C0C, 4'hF, 3'b001, -1, rd, er);
        psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
        paddr_v[0] = 32'h0C; pwdata_v[0] = 32'h0BAD0BAD; pstrb_v[0] = 4'hF; pprot_v[0] = 3'b001;
        @(posedge clk); #1;
        penable_v[0] = 1'b1;
        #2;
        presetn = 1'b0;
        bus_idle(0);
        @(negedge clk);
        check("inrst_pready", pready_v[0], 1'b0);
        check("inrst_pslverr", pslverr_v[0], 1'b0);
        @(posedge clk); #1;
        presetn = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("rst_discard", rd, 32'h5A5A0C0C);

        old = model_read(0, 32'h30);
        xfer(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 3'b000, -1, rd, er);
`ifdef APB_SLV_PROT_CHK_EN
        check("prot_user_err", er, 1'b1);
        xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("prot_user_nowrite", rd, old);
        xfer(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 3'b001, -1, rd, er);
        check("prot_priv_err", er, 1'b0);
`else
        check("prot_ignored_err", er, 1'b0);
`endif
        xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b001, -1, rd, er);
        check("prot_readback", rd, 32'h12345678);

        for (int n = 0; n < 600; n++) begin
            d = int'($urandom_range(0, 1));
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ws_of(d))) : -1;
            xfer(d, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h4F)), $urandom,
                 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), abort_at, rd, er);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++)
                xfer(i, 1'b0, 32'(w*4), 32'h0, 4'h0, 3'b001, -1, rd, er);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
